// File: rtl/cipher_pkg.sv
// Shared types, default keys and bit-permutation helpers for the stream cipher unit.
// Helpers operate on a MAX_DW-wide container; callers pass their real width in dw.
package cipher_pkg;

  localparam int MAX_DW = 64;
  localparam int IDX_W  = 6;

  // Default keys are stored replicated to MAX_DW so truncation to any DW keeps the byte pattern.
  localparam logic [MAX_DW-1:0] DEF_KEY [16] = '{
    0: {8{8'hA5}},
    1: {8{8'h3C}},
    2: {8{8'h96}},
    default: '0
  };

  typedef enum logic {
    CM_ENC = 1'b0,
    CM_DEC = 1'b1
  } cipher_mode_t;

  // y[i] = x[(5*i+3) mod dw]
  function automatic logic [MAX_DW-1:0] perm_fwd(input logic [MAX_DW-1:0] x, input int dw);
    logic [MAX_DW-1:0] y;
    y = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < dw) y[IDX_W'(i)] = x[IDX_W'((5 * i + 3) % dw)];
    end
    return y;
  endfunction

  // y[(5*i+3) mod dw] = x[i]
  function automatic logic [MAX_DW-1:0] perm_inv(input logic [MAX_DW-1:0] x, input int dw);
    logic [MAX_DW-1:0] y;
    y = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < dw) y[IDX_W'((5 * i + 3) % dw)] = x[IDX_W'(i)];
    end
    return y;
  endfunction

endpackage

// File: rtl/cipher_key_sched.sv
// Key register file plus rotating key pointer; o_cur_key is the key used by a beat accepted this cycle.
module cipher_key_sched
  import cipher_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int NKEYS = 3,
  parameter  int ROT_W = 3,
  localparam int IW    = $clog2(NKEYS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cfg_we,
  input  logic [IW-1:0] i_cfg_idx,
  input  logic [DW-1:0] i_cfg_key,
  input  logic [ROT_W-1:0] i_rot_freq,
  input  logic          i_sync_clr,
  input  logic          i_accept,
  output logic [DW-1:0] o_cur_key,
  output logic [IW-1:0] o_key_ptr
);

  logic [DW-1:0]    r_key [NKEYS];
  logic [IW-1:0]    r_ptr;
  logic [ROT_W-1:0] r_cnt;

  logic [ROT_W:0]   w_cnt_inc;
  logic             w_step;
  logic             w_idx_ok;

  assign w_cnt_inc = {1'b0, r_cnt} + {{ROT_W{1'b0}}, 1'b1};
  // ">=" rather than "==" so a rot_freq lowered below the running count steps on the next accept
  assign w_step    = (i_rot_freq != '0) && (w_cnt_inc >= {1'b0, i_rot_freq});
  assign w_idx_ok  = int'(i_cfg_idx) < NKEYS;

  assign o_cur_key = r_key[r_ptr];
  assign o_key_ptr = r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NKEYS; k++) r_key[k] <= DEF_KEY[k][DW-1:0];
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      if (i_cfg_we && w_idx_ok) r_key[i_cfg_idx] <= i_cfg_key;
      if (i_sync_clr) begin
        r_ptr <= '0;
        r_cnt <= '0;
      end else if (i_rot_freq == '0) begin
        r_cnt <= '0;
      end else if (i_accept) begin
        if (w_step) begin
          r_ptr <= (r_ptr == IW'(NKEYS - 1)) ? '0 : r_ptr + IW'(1);
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc[ROT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/stream_cipher_unit.sv
// Two-stage permute/XOR cipher with a rotating key schedule and valid/ready flow control.
// S1 holds the captured beat and its key; S2 is the registered output.
module stream_cipher_unit
  import cipher_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int NKEYS = 3,
  parameter  int ROT_W = 3,
  localparam int IW    = $clog2(NKEYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [DW-1:0]    cfg_key,
  input  logic [ROT_W-1:0] rot_freq,
  input  logic             sync_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data
);

  logic         r_s1_v;
  logic [DW-1:0] r_s1_data;
  cipher_mode_t r_s1_mode;
  logic [DW-1:0] r_s1_key;
  logic         r_out_valid;
  logic [DW-1:0] r_out_data;

  logic         w_s2_adv;
  logic         w_s1_adv;
  logic         w_accept;
  logic [DW-1:0] w_cur_key;
  logic [IW-1:0] w_key_ptr;
  logic [DW-1:0] w_fwd;
  logic [DW-1:0] w_inv;
  logic [DW-1:0] w_result;

  // Handshake: a beat moves when valid & ready are both high at a rising edge; a stalled
  // output (out_valid & !out_ready) holds data, and in_ready follows out_ready combinationally.
  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_adv  = !r_s1_v || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_accept  = in_valid && w_s1_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  cipher_key_sched #(
    .DW    (DW),
    .NKEYS (NKEYS),
    .ROT_W (ROT_W)
  ) u_key_sched (
    .clk        (clk),
    .rst        (rst),
    .i_cfg_we   (cfg_we),
    .i_cfg_idx  (cfg_idx),
    .i_cfg_key  (cfg_key),
    .i_rot_freq (rot_freq),
    .i_sync_clr (sync_clr),
    .i_accept   (w_accept),
    .o_cur_key  (w_cur_key),
    .o_key_ptr  (w_key_ptr)
  );

  assign w_fwd    = DW'(perm_fwd(MAX_DW'(r_s1_data), DW));
  assign w_inv    = DW'(perm_inv(MAX_DW'(r_s1_data ^ r_s1_key), DW));
  assign w_result = (r_s1_mode == CM_DEC) ? w_inv : (w_fwd ^ r_s1_key);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v      <= 1'b0;
      r_s1_data   <= '0;
      r_s1_mode   <= CM_ENC;
      r_s1_key    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= r_s1_v;
        if (r_s1_v) r_out_data <= w_result;
      end
      if (w_s1_adv) begin
        r_s1_v <= w_accept;
        if (w_accept) begin
          r_s1_data <= in_data;
          r_s1_mode <= cipher_mode_t'(in_mode);
          r_s1_key  <= w_cur_key;
        end
      end
    end
  end

  logic w_unused;
  assign w_unused = ^w_key_ptr;

endmodule

// File: tb/tb_stream_cipher_unit.sv
// Bench for stream_cipher_unit (DW=8, NKEYS=3, default keys): vector table, corner sequences,
// randomized traffic checked against a behavioural key-schedule/cipher model.
module tb_stream_cipher_unit;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_key;
  logic [2:0] rot_freq;
  logic       sync_clr;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  stream_cipher_unit #(.DW(8), .NKEYS(3), .ROT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_key   (cfg_key),
    .rot_freq  (rot_freq),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_fail;
  int         acc_cnt;
  bit         bp_en;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    logic       mode;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_enc(input logic [7:0] x, input logic [7:0] key);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[(5 * i + 3) % 8];
    return y ^ key;
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] x, input logic [7:0] key);
    logic [7:0] t;
    logic [7:0] y;
    t = x ^ key;
    for (int i = 0; i < 8; i++) y[(5 * i + 3) % 8] = t[i];
    return y;
  endfunction

  logic [7:0] m_key[3];
  int         m_ptr;
  int         m_cnt;

  // Monitor: inputs/out_ready change only just after a rising edge, so values seen on the
  // falling edge are exactly what the next rising edge acts on.
  always @(negedge clk) begin
    logic [7:0] k;
    logic [7:0] e;
    if (!rst) begin
      m_key[0] = 8'hA5; m_key[1] = 8'h3C; m_key[2] = 8'h96;
      m_ptr = 0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_out", 32'(out_data), 32'(e));
        end
        got_q.push_back(out_data);
      end
      if (in_valid && in_ready) begin
        k = m_key[m_ptr];
        exp_q.push_back(in_mode ? m_dec(in_data, k) : m_enc(in_data, k));
        acc_cnt++;
      end
      if (sync_clr) begin
        m_ptr = 0;
        m_cnt = 0;
      end else if (rot_freq == 3'd0) begin
        m_cnt = 0;
      end else if (in_valid && in_ready) begin
        if (m_cnt + 1 >= int'(rot_freq)) begin
          m_ptr = (m_ptr + 1) % 3;
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (cfg_we && cfg_idx < 2'd3) m_key[cfg_idx] = cfg_key;
    end
  end

  // Random output backpressure
  always @(posedge clk) begin
    if (bp_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic m, input logic [7:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    sync_clr = 1'b1;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_count", 32'(got_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2);
    logic [7:0] exp_a[3];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2;
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) check(nm, 32'(got_q[i]), 32'(exp_a[i]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] xs[$];
    logic [7:0] enc[$];
    logic [7:0] x;
    int         a0;
    int         t;

    n_cmp = 0; n_fail = 0; acc_cnt = 0; bp_en = 1'b0;
    rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; rot_freq = 3'd1;
    sync_clr = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;

    tbl[0] = '{1'b0, 8'h01, 8'hA7};
    tbl[1] = '{1'b0, 8'h01, 8'h3E};
    tbl[2] = '{1'b0, 8'h01, 8'h94};
    tbl[3] = '{1'b0, 8'h01, 8'hA7};
    tbl[4] = '{1'b1, 8'h3E, 8'h01};
    tbl[5] = '{1'b1, 8'h94, 8'h01};
    tbl[6] = '{1'b1, 8'hA7, 8'h01};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // rot_freq=1 encrypt/decrypt table, keys cycle K0,K1,K2,...
    got_q.delete();
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].mode, tbl[i].din);
      if (i == 0) check("lat_edge_n_valid", 32'(out_valid), 32'd0);
      if (i == 1) begin
        check("lat_edge_n1_valid", 32'(out_valid), 32'd1);
        check("lat_edge_n1_data", 32'(out_data), 32'hA7);
      end
    end
    wait_got(7);
    for (int i = 0; i < 7; i++) begin
      if (got_q.size() > i) check("tbl_out", 32'(got_q[i]), 32'(tbl[i].dout));
    end

    // Backpressure: only two beats fit while the sink is stalled
    pulse_sync();
    got_q.delete();
    a0 = acc_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h01;
    idle(6);
    check("bp_accepted", 32'(acc_cnt - a0), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'hA7);
    idle(3);
    check("bp_hold_data", 32'(out_data), 32'hA7);
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    check("bp_accepted_total", 32'(acc_cnt - a0), 32'd3);
    wait_got(3);
    check_got("bp_drain", 8'hA7, 8'h3E, 8'h94);

    // rot_freq=2 with sync_clr on the 4th beat
    rot_freq = 3'd2;
    pulse_sync();
    got_q.delete();
    send(1'b0, 8'h01);
    send(1'b0, 8'h01);
    send(1'b0, 8'h01);
    sync_clr = 1'b1;
    send(1'b0, 8'h01);
    sync_clr = 1'b0;
    send(1'b0, 8'h01);
    wait_got(5);
    check_got("sclr_a", 8'hA7, 8'hA7, 8'h3E);
    if (got_q.size() >= 5) begin
      check("sclr_beat4", 32'(got_q[3]), 32'h3E);
      check("sclr_beat5", 32'(got_q[4]), 32'hA7);
    end

    // cfg write racing an accept; out-of-range slot ignored
    rot_freq = 3'd0;
    pulse_sync();
    got_q.delete();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_key = 8'hFF;
    send(1'b0, 8'h01);
    cfg_we = 1'b0;
    send(1'b0, 8'h01);
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_key = 8'h00;
    idle(1);
    cfg_we = 1'b0;
    send(1'b0, 8'h01);
    wait_got(3);
    check_got("cfg", 8'hA7, 8'hFD, 8'hFD);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h01;
    repeat (4) @(posedge clk);
    #2;
    check("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    got_q.delete();
    send(1'b0, 8'h01);
    wait_got(1);
    if (got_q.size() >= 1) check("arst_after", 32'(got_q[0]), 32'hA7);

    // ENC -> DEC loopback under backpressure, 2 x 500 beats
    bp_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rot_freq = 3'($urandom_range(1, 7));
      xs.delete();
      pulse_sync();
      got_q.delete();
      for (int i = 0; i < 250; i++) begin
        x = 8'($urandom);
        xs.push_back(x);
        if ($urandom_range(0, 3) == 0) idle(1);
        send(1'b0, x);
      end
      wait_got(250);
      enc = got_q;
      got_q.delete();
      pulse_sync();
      for (int i = 0; i < enc.size(); i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send(1'b1, enc[i]);
      end
      wait_got(enc.size());
      for (int i = 0; i < got_q.size() && i < xs.size(); i++)
        check("loopback", 32'(got_q[i]), 32'(xs[i]));
    end

    // Random modes, keys, rotation changes and sync_clr against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 7) == 0) rot_freq = 3'($urandom_range(0, 7));
      sync_clr = ($urandom_range(0, 9) == 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_idx  = 2'($urandom_range(0, 3));
      cfg_key  = 8'($urandom);
      send(1'($urandom_range(0, 1)), 8'($urandom));
      sync_clr = 1'b0;
      cfg_we   = 1'b0;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    bp_en = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
